reg_issue_stage: RTL and testbench

Parametrised register-read/issue stage between the decoder and the exec ports. Accepts a bundle of `LANES` decoded instructions per cycle under a valid/ready handshake. Reads operands from an internal register file with writeback bypass and retires direct register assignments in place. Tracks in-flight destinations with a scoreboard, stalling on RAW/WAW hazards so exec ports never see stale operands.

---
 rtl/reg_issue_pkg.sv | 24 ++
 rtl/reg_scoreboard.sv | 33 +++
 rtl/reg_issue_stage.sv | 164 ++++++++++++++++
 tb/tb_reg_issue_stage.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/reg_issue_pkg.sv
// reg_issue_pkg: shared types and constants for the register-read/issue stage.
package reg_issue_pkg;
    localparam int LANE_OPC_W  = 7;
    localparam int LANE_ADDR_W = 5;
    localparam int LANE_DATA_W = 16;
    localparam logic [1:0] FT_LOADSTORE = 2'd1;
    localparam logic [LANE_OPC_W-1:0] OPC_ASSIGN0 = 7'd0;
    localparam logic [LANE_OPC_W-1:0] OPC_ASSIGN1 = 7'd10;
    typedef struct packed {
        logic                   enable;
        logic                   pwrite;
        logic                   pread;
        logic                   sread;
        logic [1:0]             ftype;
        logic [LANE_OPC_W-1:0]  opcode;
        logic [LANE_ADDR_W-1:0] prim;
        logic [LANE_DATA_W-1:0] sec;
    } lane_t;
    // Direct register assignments retire inside this stage instead of going to exec.
    function automatic logic is_assign(lane_t l);
        return l.enable && l.pwrite && l.ftype == FT_LOADSTORE &&
               (l.opcode == OPC_ASSIGN0 || l.opcode == OPC_ASSIGN1);
    endfunction
endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: busy bit per register for in-flight destinations, with a bundle-wide hazard query.
module reg_scoreboard #(
    parameter int LANES = 2,
    parameter int NREGS = 32,
    localparam int ADDR_W = $clog2(NREGS)
) (
    input  logic                         clock_i,
    input  logic                         reset_ni,
    input  logic                         flush_i,
    input  logic [NREGS-1:0]             set_i,
    input  logic [NREGS-1:0]             clr_i,
    input  logic [LANES-1:0]             enable_i,
    input  logic [LANES-1:0]             pwrite_i,
    input  logic [LANES-1:0]             pread_i,
    input  logic [LANES-1:0]             sread_i,
    input  logic [LANES-1:0][ADDR_W-1:0] prim_i,
    input  logic [LANES-1:0][ADDR_W-1:0] sec_i,
    output logic                         hazard_o
);
    logic [NREGS-1:0] busy_q, busy_d, live;
    always_comb begin
        live = busy_q & ~clr_i;
        busy_d = flush_i ? '0 : live | set_i;
        hazard_o = 1'b0;
        for (int i = 0; i < LANES; i++)
            hazard_o |= enable_i[i] && (((pread_i[i] || pwrite_i[i]) && live[prim_i[i]]) ||
                                        (sread_i[i] && live[sec_i[i]]));
    end
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) busy_q <= '0;
        else busy_q <= busy_d;
    end
endmodule

// File: rtl/reg_issue_stage.sv
// reg_issue_stage: operand read with writeback bypass, in-place register assignment,
// scoreboard stalls and a registered handoff to the exec ports.
module reg_issue_stage import reg_issue_pkg::*; #(
    parameter int LANES    = 2,
    parameter int DATA_W   = LANE_DATA_W,
    parameter int NREGS    = 32,
    parameter int OPC_W    = LANE_OPC_W,
    parameter int WB_PORTS = 4,
    localparam int ADDR_W  = $clog2(NREGS)
) (
    input  logic                       clock_i,
    input  logic                       reset_ni,
    input  logic                       flush_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [LANES-1:0]           in_enable_i,
    input  logic [LANES-1:0]           in_pwrite_i,
    input  logic [LANES-1:0]           in_pread_i,
    input  logic [LANES-1:0]           in_sread_i,
    input  logic [2*LANES-1:0]         in_ftype_i,
    input  logic [OPC_W*LANES-1:0]     in_opcode_i,
    input  logic [ADDR_W*LANES-1:0]    in_prim_i,
    input  logic [DATA_W*LANES-1:0]    in_sec_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [LANES-1:0]           out_enable_o,
    output logic [LANES-1:0]           out_wb_o,
    output logic [OPC_W*LANES-1:0]     out_opcode_o,
    output logic [2*LANES-1:0]         out_ftype_o,
    output logic [ADDR_W*LANES-1:0]    out_wbaddr_o,
    output logic [DATA_W*LANES-1:0]    out_prim_o,
    output logic [DATA_W*LANES-1:0]    out_sec_o,
    input  logic [WB_PORTS-1:0]        wb_en_i,
    input  logic [ADDR_W*WB_PORTS-1:0] wb_addr_i,
    input  logic [DATA_W*WB_PORTS-1:0] wb_data_i
);
    lane_t [LANES-1:0] lane;
    logic [LANES-1:0] asg, exe;
    logic [LANES-1:0][ADDR_W-1:0] prim_a, sec_a;
    logic [LANES-1:0][DATA_W-1:0] prd, srd;
    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [NREGS-1:0] set, clr;
    logic hazard, accept;
    logic out_valid_q, out_valid_d;
    logic [LANES-1:0] out_enable_q, out_enable_d, out_wb_q, out_wb_d;
    logic [LANES-1:0][OPC_W-1:0] out_opcode_q, out_opcode_d;
    logic [LANES-1:0][1:0] out_ftype_q, out_ftype_d;
    logic [LANES-1:0][ADDR_W-1:0] out_wbaddr_q, out_wbaddr_d;
    logic [LANES-1:0][DATA_W-1:0] out_prim_q, out_prim_d, out_sec_q, out_sec_d;

    // Operands come from the file as it stood before this bundle, plus same-cycle writebacks.
    always_comb begin
        lane = '0;
        for (int i = 0; i < LANES; i++) begin
            lane[i].enable = in_enable_i[i];
            lane[i].pwrite = in_pwrite_i[i];
            lane[i].pread  = in_pread_i[i];
            lane[i].sread  = in_sread_i[i];
            lane[i].ftype  = in_ftype_i[2*i +: 2];
            lane[i].opcode = in_opcode_i[i*OPC_W +: OPC_W];
            lane[i].prim   = in_prim_i[i*ADDR_W +: ADDR_W];
            lane[i].sec    = in_sec_i[i*DATA_W +: DATA_W];
            asg[i] = is_assign(lane[i]);
            exe[i] = lane[i].enable && !asg[i];
            prim_a[i] = lane[i].prim;
            sec_a[i] = lane[i].sec[ADDR_W-1:0];
            prd[i] = regs_q[prim_a[i]];
            srd[i] = regs_q[sec_a[i]];
            for (int p = 0; p < WB_PORTS; p++) begin
                prd[i] = (wb_en_i[p] && wb_addr_i[p*ADDR_W +: ADDR_W] == prim_a[i]) ? wb_data_i[p*DATA_W +: DATA_W] : prd[i];
                srd[i] = (wb_en_i[p] && wb_addr_i[p*ADDR_W +: ADDR_W] == sec_a[i]) ? wb_data_i[p*DATA_W +: DATA_W] : srd[i];
            end
        end
    end

    reg_scoreboard #(.LANES(LANES), .NREGS(NREGS)) u_sb (
        .clock_i  (clock_i),
        .reset_ni (reset_ni),
        .flush_i  (flush_i),
        .set_i    (set),
        .clr_i    (clr),
        .enable_i (in_enable_i),
        .pwrite_i (in_pwrite_i),
        .pread_i  (in_pread_i),
        .sread_i  (in_sread_i),
        .prim_i   (prim_a),
        .sec_i    (sec_a),
        .hazard_o (hazard)
    );

    assign in_ready_o = reset_ni && !flush_i && !hazard && (!out_valid_q || out_ready_i);
    assign accept = in_valid_i && in_ready_o;

    // Loop order sets priority: later wb ports and later lanes win; assignments land after writebacks.
    always_comb begin
        clr = '0;
        set = '0;
        regs_d = regs_q;
        for (int p = 0; p < WB_PORTS; p++) begin
            if (wb_en_i[p]) begin
                clr[wb_addr_i[p*ADDR_W +: ADDR_W]] = 1'b1;
                regs_d[wb_addr_i[p*ADDR_W +: ADDR_W]] = wb_data_i[p*DATA_W +: DATA_W];
            end
        end
        for (int i = 0; i < LANES; i++) begin
            if (accept && asg[i]) regs_d[prim_a[i]] = lane[i].sread ? srd[i] : lane[i].sec;
            if (accept && exe[i] && lane[i].pwrite) set[prim_a[i]] = 1'b1;
        end
    end

    always_comb begin
        out_valid_d  = !flush_i && (accept || (out_valid_q && !out_ready_i));
        out_enable_d = accept ? exe : out_enable_q;
        out_wb_d     = accept ? exe & in_pwrite_i : out_wb_q;
        out_opcode_d = out_opcode_q;
        out_ftype_d  = out_ftype_q;
        out_wbaddr_d = out_wbaddr_q;
        out_prim_d   = out_prim_q;
        out_sec_d    = out_sec_q;
        for (int i = 0; i < LANES; i++) begin
            if (accept) begin
                out_opcode_d[i] = exe[i] ? lane[i].opcode : '0;
                out_ftype_d[i]  = exe[i] ? lane[i].ftype : '0;
                out_wbaddr_d[i] = exe[i] ? prim_a[i] : '0;
                out_prim_d[i]   = !exe[i] ? '0 : lane[i].pread ? prd[i] : DATA_W'(prim_a[i]);
                out_sec_d[i]    = !exe[i] ? '0 : lane[i].sread ? srd[i] : lane[i].sec;
            end
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
            out_valid_q  <= 1'b0;
            out_enable_q <= '0;
            out_wb_q     <= '0;
            out_opcode_q <= '0;
            out_ftype_q  <= '0;
            out_wbaddr_q <= '0;
            out_prim_q   <= '0;
            out_sec_q    <= '0;
        end else begin
            regs_q       <= regs_d;
            out_valid_q  <= out_valid_d;
            out_enable_q <= out_enable_d;
            out_wb_q     <= out_wb_d;
            out_opcode_q <= out_opcode_d;
            out_ftype_q  <= out_ftype_d;
            out_wbaddr_q <= out_wbaddr_d;
            out_prim_q   <= out_prim_d;
            out_sec_q    <= out_sec_d;
        end
    end

    assign out_valid_o  = out_valid_q;
    assign out_enable_o = out_enable_q;
    assign out_wb_o     = out_wb_q;
    assign out_opcode_o = out_opcode_q;
    assign out_ftype_o  = out_ftype_q;
    assign out_wbaddr_o = out_wbaddr_q;
    assign out_prim_o   = out_prim_q;
    assign out_sec_o    = out_sec_q;
endmodule

// File: tb/tb_reg_issue_stage.sv
// tb_reg_issue_stage: directed vector table plus hand sequences for reg_issue_stage.
module tb_reg_issue_stage;
    import reg_issue_pkg::*;

    logic clock_i = 1'b0, reset_ni = 1'b0, flush_i = 1'b0, in_valid_i = 1'b0, out_ready_i = 1'b1;
    logic in_ready_o, out_valid_o;
    logic [1:0] in_enable_i = '0, in_pwrite_i = '0, in_pread_i = '0, in_sread_i = '0;
    logic [3:0] in_ftype_i = '0;
    logic [13:0] in_opcode_i = '0;
    logic [9:0] in_prim_i = '0;
    logic [31:0] in_sec_i = '0;
    logic [1:0] out_enable_o, out_wb_o;
    logic [13:0] out_opcode_o;
    logic [3:0] out_ftype_o;
    logic [9:0] out_wbaddr_o;
    logic [31:0] out_prim_o, out_sec_o;
    logic [3:0] wb_en_i = '0;
    logic [19:0] wb_addr_i = '0;
    logic [63:0] wb_data_i = '0;

    reg_issue_stage dut (
        .clock_i(clock_i), .reset_ni(reset_ni), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_enable_i(in_enable_i), .in_pwrite_i(in_pwrite_i), .in_pread_i(in_pread_i),
        .in_sread_i(in_sread_i), .in_ftype_i(in_ftype_i), .in_opcode_i(in_opcode_i),
        .in_prim_i(in_prim_i), .in_sec_i(in_sec_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_enable_o(out_enable_o), .out_wb_o(out_wb_o), .out_opcode_o(out_opcode_o),
        .out_ftype_o(out_ftype_o), .out_wbaddr_o(out_wbaddr_o),
        .out_prim_o(out_prim_o), .out_sec_o(out_sec_o),
        .wb_en_i(wb_en_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i)
    );

    always #5 clock_i = ~clock_i;

    typedef struct {
        lane_t l0, l1;
        logic ordy, fl;
        logic [3:0] wbe;
        logic [3:0][4:0] wa;
        logic [3:0][15:0] wd;
        logic rdy, ov;
        logic [1:0] en, wb;
        logic [15:0] p0, s0, p1, s1;
    } vec_t;

    localparam int NV = 23;
    vec_t vt [NV];
    vec_t hv;
    lane_t off_l;
    int total = 0, bad = 0;
    logic [13:0] eop = '0;
    logic [3:0] eft = '0;
    logic [9:0] ewa = '0;

    function automatic lane_t ex(logic pw, logic pr, logic sr, logic [4:0] p, logic [15:0] s);
        lane_t l;
        l.enable = 1'b1; l.pwrite = pw; l.pread = pr; l.sread = sr;
        l.ftype = 2'd2; l.opcode = 7'h13; l.prim = p; l.sec = s;
        return l;
    endfunction

    function automatic lane_t as(logic [4:0] p, logic [15:0] s);
        lane_t l;
        l.enable = 1'b1; l.pwrite = 1'b1; l.pread = 1'b0; l.sread = 1'b0;
        l.ftype = FT_LOADSTORE; l.opcode = 7'd10; l.prim = p; l.sec = s;
        return l;
    endfunction

    function automatic vec_t mk(lane_t a, lane_t b, logic ordy, logic fl, logic rdy, logic ov,
                                logic [1:0] en, logic [1:0] wb,
                                logic [15:0] p0, logic [15:0] s0, logic [15:0] p1, logic [15:0] s1);
        vec_t v;
        v.l0 = a; v.l1 = b; v.ordy = ordy; v.fl = fl; v.rdy = rdy; v.ov = ov;
        v.en = en; v.wb = wb; v.p0 = p0; v.s0 = s0; v.p1 = p1; v.s1 = s1;
        v.wbe = '0; v.wa = '0; v.wd = '0;
        return v;
    endfunction

    function automatic vec_t wbk(vec_t v, int port, logic [4:0] a, logic [15:0] d);
        v.wbe[port] = 1'b1; v.wa[port] = a; v.wd[port] = d;
        return v;
    endfunction

    task automatic apply(vec_t v);
        in_valid_i = 1'b1; flush_i = v.fl; out_ready_i = v.ordy;
        in_enable_i = {v.l1.enable, v.l0.enable};
        in_pwrite_i = {v.l1.pwrite, v.l0.pwrite};
        in_pread_i = {v.l1.pread, v.l0.pread};
        in_sread_i = {v.l1.sread, v.l0.sread};
        in_ftype_i = {v.l1.ftype, v.l0.ftype};
        in_opcode_i = {v.l1.opcode, v.l0.opcode};
        in_prim_i = {v.l1.prim, v.l0.prim};
        in_sec_i = {v.l1.sec, v.l0.sec};
        wb_en_i = v.wbe; wb_addr_i = v.wa; wb_data_i = v.wd;
    endtask

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    initial begin
        off_l = '0;
        vt[0]  = mk(as(3, 16'h00AB), off_l, 1, 0, 1, 1, 2'b00, 2'b00, 0, 0, 0, 0);
        vt[1]  = mk(ex(0, 1, 0, 3, 16'h0042), off_l, 1, 0, 1, 1, 2'b01, 2'b00, 16'h00AB, 16'h0042, 0, 0);
        vt[2]  = mk(ex(1, 0, 0, 5, 16'h0010), off_l, 1, 0, 1, 1, 2'b01, 2'b01, 16'h0005, 16'h0010, 0, 0);
        vt[3]  = mk(ex(0, 1, 0, 5, 0), off_l, 1, 0, 0, 0, 2'b01, 2'b01, 16'h0005, 16'h0010, 0, 0);
        vt[4]  = wbk(mk(ex(0, 1, 0, 5, 0), off_l, 1, 0, 1, 1, 2'b01, 2'b00, 16'h1234, 0, 0, 0), 1, 5, 16'h1234);
        vt[5]  = mk(as(7, 16'h0001), ex(0, 1, 0, 7, 16'h0003), 1, 0, 1, 1, 2'b10, 2'b00, 0, 0, 0, 16'h0003);
        vt[5].l0.opcode = 7'd0;
        vt[6]  = mk(as(7, 16'h0011), as(7, 16'h0022), 1, 0, 1, 1, 2'b00, 2'b00, 0, 0, 0, 0);
        vt[7]  = mk(ex(0, 1, 1, 7, 16'h0005), off_l, 1, 0, 1, 1, 2'b01, 2'b00, 16'h0022, 16'h1234, 0, 0);
        vt[8]  = wbk(wbk(mk(as(2, 16'h0055), off_l, 1, 0, 1, 1, 2'b00, 2'b00, 0, 0, 0, 0),
                         3, 2, 16'hFFFF), 0, 4, 16'hBEEF);
        vt[9]  = mk(ex(0, 1, 0, 2, 0), ex(0, 1, 1, 4, 16'h0003), 1, 0, 1, 1, 2'b11, 2'b00,
                    16'h0055, 0, 16'hBEEF, 16'h00AB);
        vt[10] = wbk(wbk(mk(ex(0, 1, 0, 6, 0), off_l, 1, 0, 1, 1, 2'b01, 2'b00, 16'h0C0C, 0, 0, 0),
                         0, 6, 16'h0A0A), 2, 6, 16'h0C0C);
        vt[11] = mk(ex(1, 0, 0, 9, 0), off_l, 1, 0, 1, 1, 2'b01, 2'b01, 16'h0009, 0, 0, 0);
        vt[12] = mk(off_l, ex(1, 0, 0, 9, 0), 1, 0, 0, 0, 2'b01, 2'b01, 16'h0009, 0, 0, 0);
        vt[13] = mk(off_l, ex(1, 0, 0, 9, 0), 1, 1, 0, 0, 2'b01, 2'b01, 16'h0009, 0, 0, 0);
        vt[14] = mk(off_l, ex(1, 0, 0, 9, 0), 1, 0, 1, 1, 2'b10, 2'b10, 0, 0, 16'h0009, 0);
        vt[15] = wbk(mk(ex(1, 0, 0, 9, 0), off_l, 1, 0, 1, 1, 2'b01, 2'b01, 16'h0009, 0, 0, 0), 0, 9, 16'h0999);
        vt[16] = mk(ex(0, 1, 0, 9, 0), off_l, 1, 0, 0, 0, 2'b01, 2'b01, 16'h0009, 0, 0, 0);
        vt[17] = mk(ex(0, 1, 0, 9, 0), off_l, 1, 1, 0, 0, 2'b01, 2'b01, 16'h0009, 0, 0, 0);
        vt[18] = mk(ex(0, 1, 0, 9, 0), off_l, 0, 0, 1, 1, 2'b01, 2'b00, 16'h0999, 0, 0, 0);
        for (int k = 19; k < 22; k++)
            vt[k] = mk(ex(0, 1, 0, 7, 0), off_l, 0, 0, 0, 1, 2'b01, 2'b00, 16'h0999, 0, 0, 0);
        vt[22] = mk(ex(0, 1, 0, 7, 0), off_l, 1, 0, 1, 1, 2'b01, 2'b00, 16'h0022, 0, 0, 0);

        apply(vt[0]);
        repeat (2) @(posedge clock_i);
        #1;
        chk("reset ready", {63'd0, in_ready_o}, 64'd0);
        chk("reset valid", {63'd0, out_valid_o}, 64'd0);
        chk("reset enable", {62'd0, out_enable_o}, 64'd0);
        chk("reset prim", {32'd0, out_prim_o}, 64'd0);
        reset_ni = 1'b1;

        for (int i = 0; i < NV; i++) begin
            apply(vt[i]);
            @(negedge clock_i);
            chk($sformatf("v%0d ready", i), {63'd0, in_ready_o}, {63'd0, vt[i].rdy});
            @(posedge clock_i);
            #1;
            if (vt[i].rdy) begin
                eop = {vt[i].en[1] ? vt[i].l1.opcode : 7'd0, vt[i].en[0] ? vt[i].l0.opcode : 7'd0};
                eft = {vt[i].en[1] ? vt[i].l1.ftype : 2'd0, vt[i].en[0] ? vt[i].l0.ftype : 2'd0};
                ewa = {vt[i].en[1] ? vt[i].l1.prim : 5'd0, vt[i].en[0] ? vt[i].l0.prim : 5'd0};
            end
            chk($sformatf("v%0d valid", i), {63'd0, out_valid_o}, {63'd0, vt[i].ov});
            chk($sformatf("v%0d enable", i), {62'd0, out_enable_o}, {62'd0, vt[i].en});
            chk($sformatf("v%0d wb", i), {62'd0, out_wb_o}, {62'd0, vt[i].wb});
            chk($sformatf("v%0d prim", i), {32'd0, out_prim_o}, {32'd0, vt[i].p1, vt[i].p0});
            chk($sformatf("v%0d sec", i), {32'd0, out_sec_o}, {32'd0, vt[i].s1, vt[i].s0});
            chk($sformatf("v%0d opc/ft/wa", i), {36'd0, out_opcode_o, out_ftype_o, out_wbaddr_o},
                {36'd0, eop, eft, ewa});
        end

        // Reset asserted while a stalled output and a busy bit are pending.
        hv = mk(ex(1, 0, 0, 12, 0), off_l, 1, 0, 1, 1, 2'b01, 2'b01, 16'h000C, 0, 0, 0);
        apply(hv);
        @(negedge clock_i);
        chk("rst-seq ready0", {63'd0, in_ready_o}, 64'd1);
        @(posedge clock_i);
        #1;
        chk("rst-seq valid0", {63'd0, out_valid_o}, 64'd1);
        hv = mk(ex(0, 1, 0, 12, 0), off_l, 0, 0, 0, 1, 2'b01, 2'b01, 16'h000C, 0, 0, 0);
        apply(hv);
        @(negedge clock_i);
        chk("rst-seq ready1", {63'd0, in_ready_o}, 64'd0);
        @(posedge clock_i);
        #1;
        chk("rst-seq held", {63'd0, out_valid_o}, 64'd1);
        #2 reset_ni = 1'b0;
        #1;
        chk("rst-seq valid drop", {63'd0, out_valid_o}, 64'd0);
        chk("rst-seq ready low", {63'd0, in_ready_o}, 64'd0);
        chk("rst-seq enable", {62'd0, out_enable_o}, 64'd0);
        reset_ni = 1'b1;
        hv = mk(ex(0, 1, 0, 12, 0), ex(0, 1, 0, 3, 0), 1, 0, 1, 1, 2'b11, 2'b00, 0, 0, 0, 0);
        apply(hv);
        @(negedge clock_i);
        chk("rst-seq busy cleared", {63'd0, in_ready_o}, 64'd1);
        @(posedge clock_i);
        #1;
        chk("rst-seq accept", {63'd0, out_valid_o}, 64'd1);
        chk("rst-seq file zero", {32'd0, out_prim_o}, 64'd0);
        chk("rst-seq enable2", {62'd0, out_enable_o}, 64'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
